// File: rtl/memory_cycle_scrub_pkg.sv
// Shared scrub FSM encoding, code widths and the Hamming(38,32) + overall-parity helpers.
// Codeword bit 0 is overall parity, bits at power-of-two positions 1..32 are check bits.
package memory_cycle_scrub_pkg;

  localparam int DATA_W = 32;
  localparam int CODE_W = 39;
  localparam int SYN_W  = 6;

  typedef enum logic [1:0] {
    SC_IDLE,
    SC_SCAN,
    SC_FIX
  } scrub_state_e;

  function automatic logic [SYN_W-1:0] hamming_syndrome(input logic [CODE_W-1:0] cw);
    logic [SYN_W-1:0] syn;
    syn = '0;
    for (int p = 1; p < CODE_W; p++) begin
      if (cw[p]) syn = syn ^ SYN_W'(p);
    end
    return syn;
  endfunction

  function automatic logic [CODE_W-1:0] hamming_encode(input logic [DATA_W-1:0] data);
    logic [CODE_W-1:0] cw;
    logic [SYN_W-1:0]  syn;
    int                k;
    cw = '0;
    k  = 0;
    for (int p = 1; p < CODE_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p] = data[k];
        k++;
      end
    end
    // Check bit b cancels bit b of the data-only syndrome, so a clean word has syndrome 0.
    syn = hamming_syndrome(cw);
    for (int b = 0; b < SYN_W; b++) begin
      cw[1 << b] = syn[b];
    end
    cw[0] = ^cw[CODE_W-1:1];
    return cw;
  endfunction

  function automatic logic [DATA_W-1:0] hamming_decode(input logic [CODE_W-1:0] cw);
    logic [CODE_W-1:0] fixed;
    logic [SYN_W-1:0]  syn;
    logic [DATA_W-1:0] data;
    int                k;
    syn   = hamming_syndrome(cw);
    fixed = cw;
    if (syn != '0 && int'(syn) < CODE_W) fixed[syn] = ~fixed[syn];
    data = '0;
    k    = 0;
    for (int p = 1; p < CODE_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        data[k] = fixed[p];
        k++;
      end
    end
    return data;
  endfunction

endpackage

// File: rtl/memory_cycle_scrub_ecc.sv
// Decodes one codeword and flags an error whenever the raw word differs from the clean re-encoding.
module ecc_check_unit
  import memory_cycle_scrub_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic [DATA_W-1:0] data_o,
  output logic              err_o
);

  assign data_o = hamming_decode(code_i);
  assign err_o  = (hamming_encode(data_o) != code_i);

endmodule

// File: rtl/memory_cycle_scrub.sv
// MEM stage: corrects the EX/MEM bus, accesses ECC data memory, registers a re-encoded MEM/WB bus
// and runs a background scrubber that rewrites memory words holding a single-bit error.
module memory_cycle_scrub
  import memory_cycle_scrub_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int SCRUB_INTERVAL = 1024,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic              ResultSrcM,
  input  logic [4:0]        RD_M,
  input  logic [CODE_W-1:0] ALU_ResultM_ECC,
  input  logic [CODE_W-1:0] WriteDataM_ECC,
  input  logic [CODE_W-1:0] PCPlus4M_ECC,
  output logic [DATA_W-1:0] ALU_ResultM_Out,
  output logic              RegWriteW,
  output logic              ResultSrcW,
  output logic [4:0]        RD_W,
  output logic [CODE_W-1:0] ALU_ResultW_ECC,
  output logic [CODE_W-1:0] ReadDataW_ECC,
  output logic [CODE_W-1:0] PCPlus4W_ECC,
  output logic [CNT_W-1:0]  corrected_count,
  output logic              scrub_active
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int TMR_W = $clog2(SCRUB_INTERVAL);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(SCRUB_INTERVAL - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  logic [CODE_W-1:0] mem_q [DEPTH];

  logic [DATA_W-1:0] aluData, wdData, pcData, rdData, scData;
  logic              aluErr, wdErr, pcErr, rdErr, scErr;
  logic [ADDR_W-1:0] idx;

  scrub_state_e      state_q;
  logic [TMR_W-1:0]  timer_q;
  logic [ADDR_W-1:0] scrubAddr_q;
  logic [CODE_W-1:0] fixWord_q;
  logic              scrubActive_q;
  logic              scanRead;

  logic              regWriteW_q, resultSrcW_q;
  logic [4:0]        rdW_q;
  logic [CODE_W-1:0] aluW_q, readW_q, pcW_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [2:0]        errSum;
  logic [CNT_W:0]    cntSum;

  ecc_check_unit u_alu (.code_i(ALU_ResultM_ECC),     .data_o(aluData), .err_o(aluErr));
  ecc_check_unit u_wd  (.code_i(WriteDataM_ECC),      .data_o(wdData),  .err_o(wdErr));
  ecc_check_unit u_pc  (.code_i(PCPlus4M_ECC),        .data_o(pcData),  .err_o(pcErr));
  ecc_check_unit u_rd  (.code_i(mem_q[idx]),          .data_o(rdData),  .err_o(rdErr));
  ecc_check_unit u_sc  (.code_i(mem_q[scrubAddr_q]),  .data_o(scData),  .err_o(scErr));

  assign idx             = aluData[ADDR_W+1:2];
  assign ALU_ResultM_Out = aluData;
  assign scanRead        = (state_q == SC_SCAN) && !MemWriteM && !ResultSrcM;

  // Demand stores win the single write port; a pending FIX write waits behind them.
  always_ff @(posedge clk) begin
    if (MemWriteM) begin
      mem_q[idx] <= hamming_encode(wdData);
    end else if (state_q == SC_FIX) begin
      mem_q[scrubAddr_q] <= fixWord_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= SC_IDLE;
      timer_q       <= '0;
      scrubAddr_q   <= '0;
      fixWord_q     <= '0;
      scrubActive_q <= 1'b0;
    end else begin
      case (state_q)
        SC_IDLE: begin
          if (timer_q == TMR_LAST) begin
            timer_q       <= '0;
            state_q       <= SC_SCAN;
            scrubActive_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        SC_SCAN: begin
          if (scanRead) begin
            if (scErr) begin
              fixWord_q <= hamming_encode(scData);
              state_q   <= SC_FIX;
            end else begin
              scrubAddr_q <= scrubAddr_q + 1'b1;
              if (scrubAddr_q == ADDR_LAST) begin
                state_q       <= SC_IDLE;
                scrubActive_q <= 1'b0;
              end
            end
          end
        end
        SC_FIX: begin
          // A store to the word being fixed carries newer data, so the fix is simply dropped.
          if (!MemWriteM || idx == scrubAddr_q) begin
            scrubAddr_q <= scrubAddr_q + 1'b1;
            if (scrubAddr_q == ADDR_LAST) begin
              state_q       <= SC_IDLE;
              scrubActive_q <= 1'b0;
            end else begin
              state_q <= SC_SCAN;
            end
          end
        end
        default: begin
          state_q       <= SC_IDLE;
          scrubActive_q <= 1'b0;
        end
      endcase
    end
  end

  assign errSum = {2'b00, aluErr} + {2'b00, wdErr} + {2'b00, pcErr}
                + {2'b00, rdErr & ResultSrcM} + {2'b00, scErr & scanRead};
  assign cntSum  = {1'b0, count_q} + (CNT_W + 1)'(errSum);
  assign count_d = cntSum[CNT_W] ? '1 : cntSum[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regWriteW_q  <= 1'b0;
      resultSrcW_q <= 1'b0;
      rdW_q        <= '0;
      aluW_q       <= '0;
      readW_q      <= '0;
      pcW_q        <= '0;
      count_q      <= '0;
    end else begin
      regWriteW_q  <= RegWriteM;
      resultSrcW_q <= ResultSrcM;
      rdW_q        <= RD_M;
      aluW_q       <= hamming_encode(aluData);
      readW_q      <= hamming_encode(rdData);
      pcW_q        <= hamming_encode(pcData);
      count_q      <= count_d;
    end
  end

  assign RegWriteW       = regWriteW_q;
  assign ResultSrcW      = resultSrcW_q;
  assign RD_W            = rdW_q;
  assign ALU_ResultW_ECC = aluW_q;
  assign ReadDataW_ECC   = readW_q;
  assign PCPlus4W_ECC    = pcW_q;
  assign corrected_count = count_q;
  assign scrub_active    = scrubActive_q;

endmodule

// File: tb/tb_memory_cycle_scrub.sv
// Scoreboard bench for memory_cycle_scrub: expected MEM/WB words are queued per driven op and
// popped one cycle later; scrub behaviour is checked through scrub_active timing and memory contents.
module tb_memory_cycle_scrub;
  import memory_cycle_scrub_pkg::*;

  localparam int ADDR_W = 8;
  localparam int SI     = 200;
  localparam int CNT_W  = 4;
  localparam int DEPTH  = 256;

  logic              clk;
  logic              rst;
  logic              RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]        RD_M;
  logic [38:0]       ALU_ResultM_ECC, WriteDataM_ECC, PCPlus4M_ECC;
  logic [31:0]       ALU_ResultM_Out;
  logic              RegWriteW, ResultSrcW;
  logic [4:0]        RD_W;
  logic [38:0]       ALU_ResultW_ECC, ReadDataW_ECC, PCPlus4W_ECC;
  logic [CNT_W-1:0]  corrected_count;
  logic              scrub_active;

  typedef struct packed {
    logic        regWrite;
    logic        resultSrc;
    logic [4:0]  rd;
    logic [38:0] alu;
    logic [38:0] rdata;
    logic [38:0] pc;
  } wb_t;

  wb_t         expQ[$];
  logic [31:0] shadow [DEPTH];
  int          testCount;
  int          failCount;

  memory_cycle_scrub #(.ADDR_W(ADDR_W), .SCRUB_INTERVAL(SI), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RD_M(RD_M),
    .ALU_ResultM_ECC(ALU_ResultM_ECC), .WriteDataM_ECC(WriteDataM_ECC), .PCPlus4M_ECC(PCPlus4M_ECC),
    .ALU_ResultM_Out(ALU_ResultM_Out),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
    .ALU_ResultW_ECC(ALU_ResultW_ECC), .ReadDataW_ECC(ReadDataW_ECC), .PCPlus4W_ECC(PCPlus4W_ECC),
    .corrected_count(corrected_count), .scrub_active(scrub_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference encoder: each check bit is the parity of the data positions it covers.
  function automatic logic [38:0] enc(input logic [31:0] d);
    logic [38:0] c;
    logic        par;
    int          k;
    c = '0;
    k = 0;
    for (int p = 1; p <= 38; p++) begin
      if (!(p inside {1, 2, 4, 8, 16, 32})) begin
        c[p] = d[k];
        k++;
      end
    end
    for (int b = 0; b < 6; b++) begin
      par = 1'b0;
      for (int p = 1; p <= 38; p++) begin
        if (p != (1 << b) && ((p >> b) & 1) == 1) par = par ^ c[p];
      end
      c[1 << b] = par;
    end
    c[0] = ^c;
    return c;
  endfunction

  function automatic wb_t sampleWb();
    wb_t w;
    w.regWrite  = RegWriteW;
    w.resultSrc = ResultSrcW;
    w.rd        = RD_W;
    w.alu       = ALU_ResultW_ECC;
    w.rdata     = ReadDataW_ECC;
    w.pc        = PCPlus4W_ECC;
    return w;
  endfunction

  task automatic setIdle();
    RegWriteM       = 1'b0;
    MemWriteM       = 1'b0;
    ResultSrcM      = 1'b0;
    RD_M            = '0;
    ALU_ResultM_ECC = '0;
    WriteDataM_ECC  = '0;
    PCPlus4M_ECC    = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    setIdle();
  endtask

  task automatic applyStimulus(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                               input logic [31:0] aluV, input logic [31:0] wdV, input logic [31:0] pcV,
                               input logic [38:0] aluFlip, input logic [38:0] wdFlip,
                               input logic [38:0] pcFlip);
    wb_t         e;
    logic [7:0]  i;
    RegWriteM       = rw;
    MemWriteM       = mw;
    ResultSrcM      = rs;
    RD_M            = rd;
    ALU_ResultM_ECC = enc(aluV) ^ aluFlip;
    WriteDataM_ECC  = enc(wdV) ^ wdFlip;
    PCPlus4M_ECC    = enc(pcV) ^ pcFlip;
    i           = aluV[9:2];
    e.regWrite  = rw;
    e.resultSrc = rs;
    e.rd        = rd;
    e.alu       = enc(aluV);
    e.rdata     = enc(shadow[i]);
    e.pc        = enc(pcV);
    expQ.push_back(e);
    if (mw) shadow[i] = wdV;
  endtask

  task automatic doReset();
    setIdle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    expQ.delete();
  endtask

  task automatic waitScrub(input logic level, input int bound, output int ticks);
    ticks = 0;
    while (ticks < bound) begin
      tick();
      ticks++;
      if (scrub_active === level) break;
    end
  endtask

  task automatic test_reset();
    wb_t gotV, expV;
    doReset();
    testCount++;
    if (sampleWb() !== '0 || corrected_count !== '0 || scrub_active !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_state: got wb=%h cnt=%0d act=%b expected all zero",
               sampleWb(), corrected_count, scrub_active);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd3, 32'h40, 32'h0, 32'h44, 39'd1 << 9, '0, '0);
    tick();
    gotV = sampleWb(); expV = expQ.pop_front();
    testCount++;
    if (gotV !== expV) begin
      failCount++;
      $display("[TB] FAIL reset_pre_wb: got %h expected %h", gotV, expV);
    end
    testCount++;
    if (corrected_count !== 4'd1) begin
      failCount++;
      $display("[TB] FAIL reset_pre_count: got %0d expected 1", corrected_count);
    end
    #2 rst = 1'b0;
    #1;
    testCount++;
    if (sampleWb() !== '0 || corrected_count !== '0) begin
      failCount++;
      $display("[TB] FAIL async_reset: got wb=%h cnt=%0d expected zero", sampleWb(), corrected_count);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_store_load();
    wb_t gotV, expV;
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 32'h10, 32'h12345678, 32'h104, '0, '0, '0);
    tick();
    gotV = sampleWb(); expV = expQ.pop_front();
    testCount++;
    if (gotV !== expV) begin
      failCount++;
      $display("[TB] FAIL store_wb: got %h expected %h", gotV, expV);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd5, 32'h10, 32'h0, 32'h108, '0, '0, '0);
    tick();
    gotV = sampleWb(); expV = expQ.pop_front();
    testCount++;
    if (gotV !== expV || gotV.rdata !== enc(32'h12345678)) begin
      failCount++;
      $display("[TB] FAIL load_wb: got %h expected %h", gotV, expV);
    end
    testCount++;
    if (corrected_count !== 4'd0) begin
      failCount++;
      $display("[TB] FAIL load_clean_count: got %0d expected 0", corrected_count);
    end
  endtask

  task automatic test_load_correction();
    wb_t gotV, expV;
    logic [38:0] bad;
    doReset();
    bad = enc(32'h12345678) ^ (39'd1 << 5);
    dut.mem_q[4] = bad;
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd6, 32'h10, 32'h0, 32'h10C, '0, '0, '0);
    tick();
    gotV = sampleWb(); expV = expQ.pop_front();
    testCount++;
    if (gotV !== expV) begin
      failCount++;
      $display("[TB] FAIL corrected_load_wb: got %h expected %h", gotV, expV);
    end
    testCount++;
    if (corrected_count !== 4'd1) begin
      failCount++;
      $display("[TB] FAIL corrected_load_count: got %0d expected 1", corrected_count);
    end
    testCount++;
    if (dut.mem_q[4] !== bad) begin
      failCount++;
      $display("[TB] FAIL load_no_writeback: got %h expected %h", dut.mem_q[4], bad);
    end
  endtask

  task automatic test_scrub_repair();
    int n;
    doReset();
    waitScrub(1'b1, SI + 20, n);
    testCount++;
    if (n !== SI) begin
      failCount++;
      $display("[TB] FAIL scrub_start: got %0d cycles expected %0d", n, SI);
    end
    waitScrub(1'b0, DEPTH + 40, n);
    testCount++;
    if (n !== DEPTH + 1) begin
      failCount++;
      $display("[TB] FAIL scrub_pass_len: got %0d cycles expected %0d", n, DEPTH + 1);
    end
    testCount++;
    if (dut.mem_q[4] !== enc(32'h12345678)) begin
      failCount++;
      $display("[TB] FAIL scrub_repair: got %h expected %h", dut.mem_q[4], enc(32'h12345678));
    end
    testCount++;
    if (corrected_count !== 4'd1) begin
      failCount++;
      $display("[TB] FAIL scrub_count: got %0d expected 1", corrected_count);
    end
  endtask

  task automatic test_input_errors();
    wb_t gotV, expV;
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd9, 32'h0000_0ABC, 32'hDEAD_BEEF, 32'h104,
                  39'd1, 39'd1 << 17, 39'd1 << 38);
    #1;
    testCount++;
    if (ALU_ResultM_Out !== 32'h0000_0ABC) begin
      failCount++;
      $display("[TB] FAIL forward_alu: got %h expected %h", ALU_ResultM_Out, 32'h0000_0ABC);
    end
    tick();
    gotV = sampleWb(); expV = expQ.pop_front();
    testCount++;
    if (gotV !== expV) begin
      failCount++;
      $display("[TB] FAIL input_fix_wb: got %h expected %h", gotV, expV);
    end
    testCount++;
    if (corrected_count !== 4'd3) begin
      failCount++;
      $display("[TB] FAIL input_fix_count: got %0d expected 3", corrected_count);
    end
  endtask

  task automatic test_back_to_back();
    wb_t         gotV, expV;
    logic [31:0] addrs [6];
    logic [31:0] vals  [6];
    doReset();
    addrs = '{32'h420, 32'h3FC, 32'h24, 32'h20, 32'h7FC, 32'h24};
    vals  = '{32'hCAFE_F00D, 32'h0BAD_BEEF, 32'h1357_9BDF, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(i >= 3, i < 3, i >= 3, 5'(i + 1), addrs[i], vals[i], 32'h200 + 32'(4 * i),
                    '0, '0, '0);
      tick();
      gotV = sampleWb(); expV = expQ.pop_front();
      testCount++;
      if (gotV !== expV) begin
        failCount++;
        $display("[TB] FAIL b2b_op%0d: got %h expected %h", i, gotV, expV);
      end
    end
    testCount++;
    if (corrected_count !== 4'd0) begin
      failCount++;
      $display("[TB] FAIL b2b_count: got %0d expected 0", corrected_count);
    end
  endtask

  task automatic test_fix_drop();
    wb_t gotV, expV;
    int  n;
    doReset();
    dut.mem_q[7] = enc(32'h0000_5555) ^ (39'd1 << 12);
    shadow[7]    = 32'h0000_5555;
    waitScrub(1'b1, SI + 20, n);
    repeat (8) tick();
    testCount++;
    if (dut.state_q !== SC_FIX) begin
      failCount++;
      $display("[TB] FAIL fix_state: got %0d expected %0d", dut.state_q, SC_FIX);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 32'h1C, 32'hAAAA_0000, 32'h300, '0, '0, '0);
    tick();
    gotV = sampleWb(); expV = expQ.pop_front();
    testCount++;
    if (gotV !== expV) begin
      failCount++;
      $display("[TB] FAIL fix_store_wb: got %h expected %h", gotV, expV);
    end
    waitScrub(1'b0, DEPTH + 40, n);
    testCount++;
    if (dut.mem_q[7] !== enc(32'hAAAA_0000)) begin
      failCount++;
      $display("[TB] FAIL fix_dropped: got %h expected %h", dut.mem_q[7], enc(32'hAAAA_0000));
    end
    testCount++;
    if (corrected_count !== 4'd1) begin
      failCount++;
      $display("[TB] FAIL fix_count: got %0d expected 1", corrected_count);
    end
  endtask

  task automatic test_saturation();
    wb_t        gotV, expV;
    logic [3:0] want [4];
    doReset();
    want = '{4'd12, 4'd14, 4'd15, 4'd15};
    for (int phase = 0; phase < 4; phase++) begin
      for (int c = 0; c < (phase == 0 ? 4 : 1); c++) begin
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd2, 32'h0, 32'h0, 32'h0, 39'd1 << 3,
                      (phase == 1 || phase == 2) ? 39'd0 : 39'd1 << 7, 39'd1 << 20);
        tick();
        gotV = sampleWb(); expV = expQ.pop_front();
        testCount++;
        if (gotV !== expV) begin
          failCount++;
          $display("[TB] FAIL sat_wb_p%0d: got %h expected %h", phase, gotV, expV);
        end
      end
      testCount++;
      if (corrected_count !== want[phase]) begin
        failCount++;
        $display("[TB] FAIL sat_count_p%0d: got %0d expected %0d", phase, corrected_count, want[phase]);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    int n;
    doReset();
    waitScrub(1'b1, SI + 20, n);
    repeat (50) tick();
    #2 rst = 1'b0;
    #1;
    testCount++;
    if (scrub_active !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midscan_reset_active: got %b expected 0", scrub_active);
    end
    @(negedge clk);
    rst = 1'b1;
    waitScrub(1'b1, SI + 20, n);
    testCount++;
    if (n !== SI) begin
      failCount++;
      $display("[TB] FAIL midscan_restart: got %0d cycles expected %0d", n, SI);
    end
    waitScrub(1'b0, DEPTH + 40, n);
    testCount++;
    if (n !== DEPTH) begin
      failCount++;
      $display("[TB] FAIL midscan_full_pass: got %0d cycles expected %0d", n, DEPTH);
    end
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    rst = 1'b0;
    setIdle();
    for (int i = 0; i < DEPTH; i++) begin
      dut.mem_q[i] = '0;
      shadow[i]    = '0;
    end
    test_reset();
    test_store_load();
    test_load_correction();
    test_scrub_repair();
    test_input_errors();
    test_back_to_back();
    test_fix_drop();
    test_saturation();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
